// File: rtl/lbuf_sp_arb_pkg.sv
// lbuf_sp_arb_pkg: shared constants, occupancy/read-source encodings and buffer entry type
package lbuf_sp_arb_pkg;
  localparam int LBUF_DEPTH = 240;
  localparam int ADR_WD = 8;
  localparam int DAT_WD = 32;
  typedef enum logic [1:0] {SRC_RAM, SRC_FWD, SRC_ZERO} src_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
  typedef struct packed {
    logic [ADR_WD-1:0] adr;
    logic [DAT_WD-1:0] dat;
  } ent_t;
endpackage

// File: rtl/lbuf_wbuf.sv
// lbuf_wbuf: 2-entry posted-write FIFO with occupancy state and per-entry address match.
// Ports: clk, rstn (async active-low); push/push_ent enqueue, pop dequeues head;
// rd_adr is compared against valid entries -> match[0] (oldest), match[1] (youngest);
// occ is the occupancy state, head the oldest entry, fwd_dat the youngest matching data.
module lbuf_wbuf
  import lbuf_sp_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  ent_t              push_ent,
  input  logic              pop,
  input  logic [ADR_WD-1:0] rd_adr,
  output occ_e              occ,
  output ent_t              head,
  output logic [1:0]        match,
  output logic [DAT_WD-1:0] fwd_dat
);
  occ_e occ_nxt;
  ent_t ent [2];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) occ <= EMPTY;
    else occ <= occ_nxt;
  always_comb begin
    occ_nxt = occ;
    if (push && !pop) occ_nxt = (occ == EMPTY) ? ONE : FULL;
    else if (pop && !push) occ_nxt = (occ == FULL) ? ONE : EMPTY;
  end
  // entry 0 is always the oldest; a pop shifts entry 1 down
  always_ff @(posedge clk) begin
    if (pop) ent[0] <= (occ == FULL) ? ent[1] : push_ent;
    else if (push && occ == EMPTY) ent[0] <= push_ent;
    if (push && (occ == FULL || (occ == ONE && !pop))) ent[1] <= push_ent;
  end
  assign head = ent[0];
  assign match = {occ == FULL && ent[1].adr == rd_adr, occ != EMPTY && ent[0].adr == rd_adr};
  assign fwd_dat = match[1] ? ent[1].dat : ent[0].dat;
endmodule

// File: rtl/lbuf_sp_arb.sv
// lbuf_sp_arb: serialises write/read request streams onto one single-port RAM via a 2-entry write buffer.
// Ports: clk, rstn (async active-low); wr_req_i/wr_adr_i/wr_dat_i -> wr_ack_o;
// rd_req_i/rd_adr_i -> rd_ack_o, then rd_val_o/rd_dat_o one cycle later;
// ram_adr_o/ram_wr_ena_o/ram_wr_dat_o/ram_rd_ena_o drive the RAM, ram_rd_dat_i is its read data.
// Build option LBUF_FWD_EN: serve reads that hit a buffered write from the buffer instead of stalling.
module lbuf_sp_arb
  import lbuf_sp_arb_pkg::*;
#(
  parameter int DEPTH = LBUF_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_req_i,
  input  logic [ADR_WD-1:0] wr_adr_i,
  input  logic [DAT_WD-1:0] wr_dat_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADR_WD-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic [ADR_WD-1:0] ram_adr_o,
  output logic              ram_wr_ena_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);
  localparam logic [ADR_WD-1:0] LAST = ADR_WD'(DEPTH - 1);
  occ_e occ;
  ent_t head;
  src_e src, src_q;
  logic [1:0] match;
  logic [DAT_WD-1:0] fwd_dat, fwd_q;
  logic push, pop, hazard;
  lbuf_wbuf u_wbuf (
    .clk(clk), .rstn(rstn), .push(push), .push_ent({wr_adr_i, wr_dat_i}), .pop(pop),
    .rd_adr(rd_adr_i), .occ(occ), .head(head), .match(match), .fwd_dat(fwd_dat)
  );
  assign wr_ack_o = wr_req_i && occ != FULL;
  assign push = wr_ack_o && wr_adr_i <= LAST;
  assign hazard = |match;
`ifdef LBUF_FWD_EN
  assign rd_ack_o = rd_req_i && occ != FULL;
`else
  assign rd_ack_o = rd_req_i && occ != FULL && !hazard;
`endif
  assign src = (rd_adr_i > LAST) ? SRC_ZERO : hazard ? SRC_FWD : SRC_RAM;
  assign ram_rd_ena_o = rd_ack_o && src == SRC_RAM;
  // any cycle the RAM is not reading drains the head; FULL always lands here since reads are refused
  assign pop = occ != EMPTY && !ram_rd_ena_o;
  assign ram_wr_ena_o = pop;
  assign ram_wr_dat_o = pop ? head.dat : '0;
  assign ram_adr_o = ram_rd_ena_o ? rd_adr_i : pop ? head.adr : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_val_o <= 1'b0;
      src_q <= SRC_ZERO;
      fwd_q <= '0;
    end else begin
      rd_val_o <= rd_ack_o;
      src_q <= rd_ack_o ? src : SRC_ZERO;
      fwd_q <= fwd_dat;
    end
  assign rd_dat_o = (src_q == SRC_RAM) ? ram_rd_dat_i : (src_q == SRC_FWD) ? fwd_q : '0;
endmodule

// File: tb/tb_lbuf_sp_arb.sv
// tb_lbuf_sp_arb: table-driven per-cycle checks of lbuf_sp_arb against a behavioural RAM
module tb_lbuf_sp_arb;
  typedef struct {
    logic wq; logic [7:0] wa; logic [31:0] wd; logic rq; logic [7:0] ra;
    logic ewa; logic era; logic erv; logic [31:0] erd;
    logic ewe; logic ere; logic [7:0] ead; logic [31:0] ewd;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_adr = '0, rd_adr = '0;
  logic [31:0] wr_dat = '0;
  logic wr_ack, rd_ack, rd_val, ram_wr_ena, ram_rd_ena;
  logic [31:0] rd_dat, ram_wr_dat, ram_q;
  logic [7:0] ram_adr;
  logic [31:0] mem [0:255];
  int n_cmp = 0, n_err = 0;
  vec_t tbl [25];
  vec_t hz [4];
  vec_t rs [3];
  lbuf_sp_arb dut (
    .clk(clk), .rstn(rstn), .wr_req_i(wr_req), .wr_adr_i(wr_adr), .wr_dat_i(wr_dat),
    .wr_ack_o(wr_ack), .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_ack_o(rd_ack),
    .rd_val_o(rd_val), .rd_dat_o(rd_dat), .ram_adr_o(ram_adr), .ram_wr_ena_o(ram_wr_ena),
    .ram_wr_dat_o(ram_wr_dat), .ram_rd_ena_o(ram_rd_ena), .ram_rd_dat_i(ram_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wr_ena) mem[ram_adr] <= ram_wr_dat;
    if (ram_rd_ena) ram_q <= mem[ram_adr];
  end
  function automatic vec_t v(logic wq, logic [7:0] wa, logic [31:0] wd, logic rq, logic [7:0] ra,
                             logic ewa, logic era, logic erv, logic [31:0] erd,
                             logic ewe, logic ere, logic [7:0] ead, logic [31:0] ewd);
    vec_t r;
    r.wq = wq; r.wa = wa; r.wd = wd; r.rq = rq; r.ra = ra;
    r.ewa = ewa; r.era = era; r.erv = erv; r.erd = erd;
    r.ewe = ewe; r.ere = ere; r.ead = ead; r.ewd = ewd;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input vec_t t, input string nm);
    @(posedge clk);
    #1;
    wr_req = t.wq; wr_adr = t.wa; wr_dat = t.wd; rd_req = t.rq; rd_adr = t.ra;
    @(negedge clk);
    chk({nm, ".wr_ack"}, 32'(wr_ack), 32'(t.ewa));
    chk({nm, ".rd_ack"}, 32'(rd_ack), 32'(t.era));
    chk({nm, ".rd_val"}, 32'(rd_val), 32'(t.erv));
    chk({nm, ".ram_wr_ena"}, 32'(ram_wr_ena), 32'(t.ewe));
    chk({nm, ".ram_rd_ena"}, 32'(ram_rd_ena), 32'(t.ere));
    if (t.erv) chk({nm, ".rd_dat"}, rd_dat, t.erd);
    if (t.ewe || t.ere) chk({nm, ".ram_adr"}, 32'(ram_adr), 32'(t.ead));
    if (t.ewe) chk({nm, ".ram_wr_dat"}, ram_wr_dat, t.ewd);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, ".wr_ack"}, 32'(wr_ack), 0);
    chk({nm, ".rd_ack"}, 32'(rd_ack), 0);
    chk({nm, ".rd_val"}, 32'(rd_val), 0);
    chk({nm, ".rd_dat"}, rd_dat, 0);
    chk({nm, ".ram_adr"}, 32'(ram_adr), 0);
    chk({nm, ".ram_wr_ena"}, 32'(ram_wr_ena), 0);
    chk({nm, ".ram_wr_dat"}, ram_wr_dat, 0);
    chk({nm, ".ram_rd_ena"}, 32'(ram_rd_ena), 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    ram_q = '0;
    tbl[0]  = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    tbl[1]  = v(1, 5, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0,            0, 0, 0, 0);
    tbl[2]  = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            1, 0, 5, 32'hDEADBEEF);
    tbl[3]  = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    tbl[4]  = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    tbl[5]  = v(0, 0, 0, 1, 5,            0, 1, 0, 0,            0, 1, 5, 0);
    tbl[6]  = v(0, 0, 0, 0, 0,            0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[7]  = v(1, 0, 32'h100, 1, 100,    1, 1, 0, 0,            0, 1, 100, 0);
    tbl[8]  = v(1, 1, 32'h101, 1, 100,    1, 1, 1, 32'hA0000064, 0, 1, 100, 0);
    tbl[9]  = v(1, 2, 32'h102, 1, 100,    0, 0, 1, 32'hA0000064, 1, 0, 0, 32'h100);
    tbl[10] = v(1, 2, 32'h102, 1, 100,    1, 1, 0, 0,            0, 1, 100, 0);
    tbl[11] = v(0, 0, 0, 1, 100,          0, 0, 1, 32'hA0000064, 1, 0, 1, 32'h101);
    tbl[12] = v(0, 0, 0, 1, 100,          0, 1, 0, 0,            0, 1, 100, 0);
    tbl[13] = v(0, 0, 0, 0, 0,            0, 0, 1, 32'hA0000064, 1, 0, 2, 32'h102);
    tbl[14] = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    tbl[15] = v(0, 0, 0, 1, 0,            0, 1, 0, 0,            0, 1, 0, 0);
    tbl[16] = v(0, 0, 0, 1, 1,            0, 1, 1, 32'h100,      0, 1, 1, 0);
    tbl[17] = v(0, 0, 0, 1, 2,            0, 1, 1, 32'h101,      0, 1, 2, 0);
    tbl[18] = v(0, 0, 0, 0, 0,            0, 0, 1, 32'h102,      0, 0, 0, 0);
    tbl[19] = v(1, 240, 32'hFF, 0, 0,     1, 0, 0, 0,            0, 0, 0, 0);
    tbl[20] = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    tbl[21] = v(0, 0, 0, 1, 239,          0, 1, 0, 0,            0, 1, 239, 0);
    tbl[22] = v(0, 0, 0, 1, 255,          0, 1, 1, 32'hA00000EF, 0, 0, 0, 0);
    tbl[23] = v(0, 0, 0, 0, 0,            0, 0, 1, 0,            0, 0, 0, 0);
    tbl[24] = v(0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    hz[0] = v(1, 7, 32'h11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef LBUF_FWD_EN
    hz[1] = v(0, 0, 0, 1, 7, 0, 1, 0, 0,      1, 0, 7, 32'h11);
    hz[2] = v(0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0);
    hz[3] = v(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0);
`else
    hz[1] = v(0, 0, 0, 1, 7, 0, 0, 0, 0,      1, 0, 7, 32'h11);
    hz[2] = v(0, 0, 0, 1, 7, 0, 1, 0, 0,      0, 1, 7, 0);
    hz[3] = v(0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0);
`endif
    rs[0] = v(0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    rs[1] = v(0, 0, 0, 1, 9, 0, 1, 0, 0,           0, 1, 9, 0);
    rs[2] = v(0, 0, 0, 0, 0, 0, 0, 1, 32'hA0000009, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 25; i++) cyc(tbl[i], $sformatf("t%0d", i));
    for (int i = 0; i < 4; i++) cyc(hz[i], $sformatf("haz%0d", i));
    cyc(v(1, 9, 32'h99, 1, 5, 1, 1, 0, 0, 0, 1, 5, 0), "mid_rd");
    @(posedge clk);
    #1;
    rstn = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk_zero("mid_rst");
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(rs[i], $sformatf("post_rst%0d", i));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
